// File: rtl/md_unit_if.sv
// Execute-stage <-> multiply/divide unit bundle: operation request, operands,
// cancel request, plus the busy flag and the HI/LO read-back value.
interface md_unit_if;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        int_req;
  logic        busy;
  logic [31:0] result;

  modport master (output op, a, b, int_req, input busy, result);
  modport slave  (input op, a, b, int_req, output busy, result);
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO; result is precomputed at issue and retired after a fixed latency.
// Optional multiply-accumulate ops (9-12) are built only when MD_MADD_EN is defined.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_unit_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] hi, hi_n, lo, lo_n;
  logic [63:0] stg_p0, stg_n;

  // Returns {remainder, quotient}; divide-by-zero and INT_MIN/-1 never reach the divider.
  function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
    logic signed [31:0] ns, ds, q, r;
    if (d == 32'd0) return {n, 32'hFFFF_FFFF};
    if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    ns = n;
    ds = d;
    q  = ns / ds;
    r  = ns % ds;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
    if (d == 32'd0) return {n, 32'hFFFF_FFFF};
    return {n % d, n / d};
  endfunction

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic [63:0] prod_u;

  assign a_sx   = {{32{md.a[31]}}, md.a};
  assign b_sx   = {{32{md.b[31]}}, md.b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, md.a} * {32'd0, md.b};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    stg_n   = stg_p0;
    case (state)
      IDLE: begin
        if (!md.int_req) begin
          case (md.op)
            OP_MULT:  begin stg_n = prod_s; cnt_n = MULT_N; state_n = RUN; end
            OP_MULTU: begin stg_n = prod_u; cnt_n = MULT_N; state_n = RUN; end
            OP_DIV:   begin stg_n = div_signed(md.a, md.b);   cnt_n = DIV_N; state_n = RUN; end
            OP_DIVU:  begin stg_n = div_unsigned(md.a, md.b); cnt_n = DIV_N; state_n = RUN; end
            OP_MTHI:  hi_n = md.a;
            OP_MTLO:  lo_n = md.a;
`ifdef MD_MADD_EN
            // Accumulate against HI/LO as they stand at the issue edge, modulo 2^64.
            OP_MADD:  begin stg_n = {hi, lo} + prod_s; cnt_n = MULT_N; state_n = RUN; end
            OP_MADDU: begin stg_n = {hi, lo} + prod_u; cnt_n = MULT_N; state_n = RUN; end
            OP_MSUB:  begin stg_n = {hi, lo} - prod_s; cnt_n = MULT_N; state_n = RUN; end
            OP_MSUBU: begin stg_n = {hi, lo} - prod_u; cnt_n = MULT_N; state_n = RUN; end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt <= 4'd1) begin
          {hi_n, lo_n} = stg_p0;
          cnt_n        = 4'd0;
          state_n      = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Issue / retire stage boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      stg_p0 <= 64'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hi     <= hi_n;
      lo     <= lo_n;
      stg_p0 <= stg_n;
    end
  end

  assign md.busy   = (state == RUN);
  assign md.result = (md.op == OP_MFHI) ? hi :
                     (md.op == OP_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic, cancel, MT/MF and async reset.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  md_unit_if ifc ();
  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(ifc.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic irq);
    ifc.op = op; ifc.a = a; ifc.b = b; ifc.int_req = irq;
    @(posedge clk); #1;
    ifc.op = 4'd0; ifc.int_req = 1'b0;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    ifc.op = 4'd5; #1;
    check({tag, "_hi"}, ifc.result, ehi);
    ifc.op = 4'd6; #1;
    check({tag, "_lo"}, ifc.result, elo);
    ifc.op = 4'd0; #1;
  endtask

  task automatic wait_idle(input string tag, input int exp_n, input int already);
    int n = already;
    while (ifc.busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, exp_n);
  endtask

  initial begin
    reset = 1'b0;
    ifc.op = 4'd0; ifc.a = 32'd0; ifc.b = 32'd0; ifc.int_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, ifc.busy}, 32'd0);
    read_hilo("reset", 32'd0, 32'd0);
    check("result_none", ifc.result, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // MULT -3 * 5
    issue(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_busy", {31'd0, ifc.busy}, 32'd1);
    wait_idle("mult_cycles", MC, 0);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // DIVU 7/2 with an illegal MFHI/MTHI while busy
    issue(4'd4, 32'd7, 32'd2, 1'b0);
    ifc.op = 4'd5; #1;
    check("busy_mfhi", ifc.result, 32'hFFFF_FFFF);
    issue(4'd7, 32'h0000_0999, 32'd0, 1'b0);
    wait_idle("divu_cycles", DC, 1);
    read_hilo("divu", 32'd1, 32'd3);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle("div_cycles", DC, 0);
    read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle("div_ovf_cycles", DC, 0);
    read_hilo("div_ovf", 32'd0, 32'h8000_0000);

    issue(4'd4, 32'h0000_1234, 32'd0, 1'b0);
    wait_idle("divz_cycles", DC, 0);
    read_hilo("divz", 32'h0000_1234, 32'hFFFF_FFFF);

    // Cancelled issue
    issue(4'd1, 32'd3, 32'd3, 1'b1);
    check("irq_busy", {31'd0, ifc.busy}, 32'd0);
    issue(4'd8, 32'h55, 32'd0, 1'b1);
    read_hilo("irq", 32'h0000_1234, 32'hFFFF_FFFF);

    issue(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(4'd8, 32'h55, 32'd0, 1'b0);
    read_hilo("mt", 32'hDEAD_BEEF, 32'h55);

    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle("multu_cycles", MC, 0);
    read_hilo("multu", 32'd1, 32'hFFFF_FFFE);

`ifdef MD_MADD_EN
    issue(4'd7, 32'd0, 32'd0, 1'b0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(4'd10, 32'd1, 32'd1, 1'b0);
    wait_idle("maddu_cycles", MC, 0);
    read_hilo("maddu", 32'd1, 32'd0);
`else
    issue(4'd9, 32'd7, 32'd7, 1'b0);
    check("op9_busy", {31'd0, ifc.busy}, 32'd0);
    read_hilo("op9", 32'd1, 32'hFFFF_FFFE);
`endif

    // Async reset in the third busy cycle
    issue(4'd1, 32'd3, 32'd4, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_busy", {31'd0, ifc.busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, ifc.busy}, 32'd0);
    read_hilo("rst_now", 32'd0, 32'd0);
    reset = 1'b1;
    repeat (MC + 1) @(posedge clk);
    #1;
    check("rst_busy_late", {31'd0, ifc.busy}, 32'd0);
    read_hilo("rst_late", 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit instantiated inside the execute stage, next to the ALU.
- Consumes the forwarded GRF operands of the instruction in E and owns the architectural HI/LO registers.
- Drives the busy flag that the decode stage uses to stall later md instructions.
- Returns the HI/LO read value to the execute stage's result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu (range 1..15)
- DIV_CYCLES, 10, busy duration of div/divu (range 1..15)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- op  input  4  md operation of the instruction in E: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-12 see Optional Feature
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- int_req  input  1  CP0 exception/interrupt request; cancels the instruction currently in E
- busy  output  1  long operation in flight
- result  output  32  HI when op==MFHI, LO when op==MFLO, else 0 (combinational)

Behaviour:
- Reset (asynchronous, reset==0): HI=0, LO=0, busy=0, countdown=0, staged results=0. Effective immediately, with no clock needed.
- Reset mid-operation: the operation is aborted; HI/LO become 0 and are not updated afterwards.
- State machine: IDLE and RUN.
  - IDLE -> RUN at a clock edge when op is in {MULT, MULTU, DIV, DIVU}, int_req==0 and busy==0.
  - On that edge: compute the full 64-bit result from a/b into staging registers, load countdown with MULT_CYCLES or DIV_CYCLES, busy=1.
- RUN:
  - countdown decrements each edge.
  - At the edge where countdown goes 1->0: copy staging into HI/LO, busy=0, return to IDLE.
  - busy is high for exactly N cycles after the issue edge.
  - The new HI/LO values are visible on result in the first cycle busy is low.
- int_req during RUN has no effect. The issuing instruction has already left E, so the operation completes.
- int_req==1 in the issue cycle: no state change. Covers all ops, including MTHI/MTLO.
- op != NONE while busy==1: ignored; HI/LO are not modified. Decode stalls this case, so it is never legal.
  - MFHI/MFLO in this case still return the current HI/LO, not the staged values.
- MTHI/MTLO with busy==0 and int_req==0: HI (or LO) <= a at the edge.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
  - MULTU: same, unsigned.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
- Boundary conditions:
  - Divide by zero (b==0, DIV or DIVU): HI = a, LO = 32'hFFFFFFFF. busy still runs DIV_CYCLES.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- result is purely combinational from op, HI and LO.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: op codes are enabled as follows, each issued like MULT with MULT_CYCLES latency:
  - 9 MADD: {HI,LO} += signed a*b
  - 10 MADDU: unsigned accumulate
  - 11 MSUB: {HI,LO} -= signed a*b
  - 12 MSUBU: unsigned subtract
  - Accumulation uses the HI/LO values at the issue edge and wraps modulo 2^64.
- Undefined: op codes 9-12 are treated as NONE, and no accumulator adder is synthesised.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> busy high exactly 5 cycles; then MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFF1.
- DIVU a=7, b=2 -> busy 10 cycles; then HI=1, LO=3. DIV a=0xFFFFFFF9 (-7), b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU a=0x1234, b=0 -> HI=0x1234, LO=0xFFFFFFFF.
- MULT with int_req=1 in the issue cycle -> busy stays 0, HI/LO unchanged. MTLO a=0x55 with int_req=1 -> LO unchanged.
- MTHI a=0xDEADBEEF, next cycle MFHI -> result=0xDEADBEEF. Issue MULT; pull reset low at cycle 3 of busy -> busy=0, HI=LO=0 immediately, still 0 after MULT_CYCLES.
- With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU a=1, b=1 -> HI=1, LO=0. Without MD_MADD_EN: op=9 -> no busy, HI/LO unchanged.
